// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 @ 60 Hz timing constants shared by the VGA sync blocks.
// Derived totals and sync windows are kept here next to the raw values.
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_CLK_DIV   = 4;

    localparam int VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock into a one-clock pixel enable.
// pre_tick fires the clock before p_tick so callers can register on it.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic p_tick,
    output logic pre_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] PRE  = DW'(CLK_DIV - 2);

    logic [DW-1:0] div;

    // Free-running divider, wraps after CLK_DIV clocks
    always_ff @(posedge clock) begin
        if (reset)
            div <= '0;
        else if (div == LAST)
            div <= '0;
        else
            div <= div + DW'(1);
    end

    assign p_tick   = (div == LAST);
    assign pre_tick = (div == PRE);

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA H/V counters with registered, counter-aligned syncs.
// Define VGA_SYNC_FRAME_TICK_EN to generate the per-frame frame_tick strobe.
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic       clock,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic       pre_tick;
    logic [9:0] x_next;
    logic [9:0] y_next;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .p_tick   (p_tick),
        .pre_tick (pre_tick)
    );

    // Next counter values: advance one pixel per p_tick, wrap line and frame
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == X_MAX) begin
                x_next = '0;
                y_next = (y == Y_MAX) ? '0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Counters and syncs; syncs decode the next counters to stay aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            x     <= x_next;
            y     <= y_next;
            hsync <= !((x_next >= HS_START) && (x_next <= HS_END));
            vsync <= !((y_next >= VS_START) && (y_next <= VS_END));
        end
    end

    assign display_on = (x < X_VIS) && (y < Y_VIS);

`ifdef VGA_SYNC_FRAME_TICK_EN
    localparam logic [9:0] Y_FT = 10'(V_DISPLAY + 1);

    // Strobe lands on the p_tick clock of pixel (0, V_DISPLAY+1)
    always_ff @(posedge clock) begin
        if (reset)
            frame_tick <= 1'b0;
        else
            frame_tick <= pre_tick && (x == '0) && (y == Y_FT);
    end
`else
    logic unused_pre_tick;

    assign unused_pre_tick = pre_tick;
    assign frame_tick      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: scoreboard bench for vga_sync, default and reduced timings.
// A closed-form pixel model supplies expected outputs per clock.
module tb_vga_sync;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       pt;
        logic       ft;
    } obs_t;

    // Reduced timing for the second instance: 30 x 19, 2280 clocks/frame
    localparam int S_HD = 16, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VD = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = 30, S_VT = 19, S_FR = 2280;

`ifdef VGA_SYNC_FRAME_TICK_EN
    localparam int FT_EN = 1;
`else
    localparam int FT_EN = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hs0, vs0, de0, pt0, ft0;
    logic       hs1, vs1, de1, pt1, ft1;
    logic [9:0] x0, y0, x1, y1;
    obs_t       obs0, obs1;

    int   checks = 0;
    int   fails  = 0;
    int   k      = 0;
    obs_t q0[$];
    obs_t q1[$];

    always #5 clock = ~clock;

    vga_sync d0 (
        .clock      (clock),
        .reset      (reset),
        .hsync      (hs0),
        .vsync      (vs0),
        .display_on (de0),
        .p_tick     (pt0),
        .x          (x0),
        .y          (y0),
        .frame_tick (ft0)
    );

    vga_sync #(
        .H_DISPLAY (S_HD), .H_FRONT (S_HF),
        .H_SYNC    (S_HS), .H_BACK  (S_HB),
        .V_DISPLAY (S_VD), .V_FRONT (S_VF),
        .V_SYNC    (S_VS), .V_BACK  (S_VB),
        .CLK_DIV   (4)
    ) d1 (
        .clock      (clock),
        .reset      (reset),
        .hsync      (hs1),
        .vsync      (vs1),
        .display_on (de1),
        .p_tick     (pt1),
        .x          (x1),
        .y          (y1),
        .frame_tick (ft1)
    );

    assign obs0 = {x0, y0, hs0, vs0, de0, pt0, ft0};
    assign obs1 = {x1, y1, hs1, vs1, de1, pt1, ft1};

    function automatic obs_t model(int kk, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb);
        obs_t o;
        int ht, vt, pix, xx, yy;
        ht   = hd + hf + hsw + hb;
        vt   = vd + vf + vsw + vb;
        pix  = kk / 4;
        xx   = pix % ht;
        yy   = (pix / ht) % vt;
        o.x  = 10'(xx);
        o.y  = 10'(yy);
        o.pt = ((kk % 4) == 3);
        o.hs = !((xx >= hd + hf) && (xx <= hd + hf + hsw - 1));
        o.vs = !((yy >= vd + vf) && (yy <= vd + vf + vsw - 1));
        o.de = (xx < hd) && (yy < vd);
        o.ft = (FT_EN != 0) && o.pt && (xx == 0) && (yy == vd + 1);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d hs=%b vs=%b de=%b pt=%b ft=%b",
                         o.x, o.y, o.hs, o.vs, o.de, o.pt, o.ft);
    endfunction

    // One clock: model advances at the edge, DUT is sampled at negedge
    task automatic tick();
        @(posedge clock);
        if (reset) k = 0;
        else k++;
        q0.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33));
        q1.push_back(model(k, S_HD, S_HF, S_HS, S_HB,
                           S_VD, S_VF, S_VS, S_VB));
        @(negedge clock);
    endtask

    task automatic test_reset();
        obs_t e0, e1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs0 !== e0) begin
                fails++;
                $display("FAIL reset_d0: got %s need %s", fmt(obs0), fmt(e0));
            end
            checks++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL reset_d1: got %s need %s", fmt(obs1), fmt(e1));
            end
        end
    endtask

    task automatic test_pixel_enable();
        obs_t e0, e1;
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs0 !== e0) begin
                fails++;
                $display("FAIL pix_d0 %0d: got %s need %s",
                         i, fmt(obs0), fmt(e0));
            end
            checks++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL pix_d1 %0d: got %s need %s",
                         i, fmt(obs1), fmt(e1));
            end
            checks++;
            if (pt0 !== (i % 4 == 3) || x0 !== 10'(i / 4)) begin
                fails++;
                $display("FAIL pix_step %0d: got pt=%b x=%0d need pt=%b x=%0d",
                         i, pt0, x0, (i % 4 == 3), i / 4);
            end
        end
    endtask

    task automatic test_horizontal();
        obs_t e0, e1;
        int hs_low = 0, de_low = 0, wraps = 0, hs_at = -1;
        logic [9:0] px, py;
        logic phs;
        for (int i = 0; i < 3200; i++) begin
            px  = x0;
            py  = y0;
            phs = hs0;
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs0 !== e0) begin
                fails++;
                $display("FAIL horiz_d0: got %s need %s", fmt(obs0), fmt(e0));
            end
            checks++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL horiz_d1: got %s need %s", fmt(obs1), fmt(e1));
            end
            if (!hs0) hs_low++;
            if (!de0) de_low++;
            if (phs && !hs0) hs_at = int'(x0);
            if (px == 10'd799 && x0 == 10'd0) begin
                wraps++;
                checks++;
                if (y0 !== py + 10'd1) begin
                    fails++;
                    $display("FAIL hwrap_y: got %0d need %0d", y0, py + 1);
                end
            end
        end
        checks++;
        if (hs_low !== 384) begin
            fails++;
            $display("FAIL hsync_len: got %0d need 384", hs_low);
        end
        checks++;
        if (hs_at !== 656) begin
            fails++;
            $display("FAIL hsync_start: got %0d need 656", hs_at);
        end
        checks++;
        if (de_low !== 640) begin
            fails++;
            $display("FAIL hblank_len: got %0d need 640", de_low);
        end
        checks++;
        if (wraps !== 1) begin
            fails++;
            $display("FAIL hwrap_cnt: got %0d need 1", wraps);
        end
    endtask

    task automatic test_vertical();
        obs_t e0, e1;
        int vs_low = 0, bad = 0, wraps = 0, w0 = -1, w1 = -1;
        logic [9:0] px, py;
        for (int i = 0; i < 4600; i++) begin
            px = x1;
            py = y1;
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs0 !== e0) begin
                fails++;
                $display("FAIL vert_d0: got %s need %s", fmt(obs0), fmt(e0));
            end
            checks++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL vert_d1: got %s need %s", fmt(obs1), fmt(e1));
            end
            if (i < S_FR && !vs1) vs_low++;
            if (!vs1 && (y1 < 10'd14 || y1 > 10'd15)) bad++;
            if (py == 10'(S_VT - 1) && y1 == 10'd0) begin
                wraps++;
                if (w0 < 0) w0 = i;
                else if (w1 < 0) w1 = i;
                checks++;
                if (px !== 10'(S_HT - 1) || x1 !== 10'd0) begin
                    fails++;
                    $display("FAIL vwrap_x: got %0d->%0d need %0d->0",
                             px, x1, S_HT - 1);
                end
            end
        end
        checks++;
        if (vs_low !== 240) begin
            fails++;
            $display("FAIL vsync_len: got %0d need 240", vs_low);
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL vsync_pos: got %0d stray clocks need 0", bad);
        end
        checks++;
        if (wraps < 2 || (w1 - w0) !== S_FR) begin
            fails++;
            $display("FAIL frame_len: got %0d (wraps %0d) need %0d",
                     w1 - w0, wraps, S_FR);
        end
    endtask

    task automatic test_frame_tick();
        obs_t e0, e1;
        int n1 = 0, n0 = 0, bad = 0;
        for (int i = 0; i < 2 * S_FR; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs0 !== e0) begin
                fails++;
                $display("FAIL ftick_d0: got %s need %s", fmt(obs0), fmt(e0));
            end
            checks++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL ftick_d1: got %s need %s", fmt(obs1), fmt(e1));
            end
            if (ft0) n0++;
            if (ft1) begin
                n1++;
                if (!(pt1 && x1 == 10'd0 && y1 == 10'(S_VD + 1))) bad++;
            end
        end
        checks++;
        if (n1 !== 2 * FT_EN || bad !== 0) begin
            fails++;
            $display("FAIL ftick_cnt: got %0d (bad %0d) need %0d",
                     n1, bad, 2 * FT_EN);
        end
        checks++;
        if (n0 !== 0) begin
            fails++;
            $display("FAIL ftick_d0_cnt: got %0d need 0", n0);
        end
    endtask

    task automatic test_bounds();
        obs_t e0, e1;
        for (int i = 0; i < 3 * S_FR; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL bounds_d1: got %s need %s", fmt(obs1), fmt(e1));
            end
            checks++;
            if (x1 > 10'(S_HT - 1) || y1 > 10'(S_VT - 1) ||
                (de1 && (x1 >= 10'(S_HD) || y1 >= 10'(S_VD)))) begin
                fails++;
                $display("FAIL bounds_rng: got x=%0d y=%0d de=%b",
                         x1, y1, de1);
            end
            checks++;
            if (x0 > 10'd799 || y0 > 10'd524 || obs0 !== e0 ||
                (de0 && (x0 >= 10'd640 || y0 >= 10'd480))) begin
                fails++;
                $display("FAIL bounds_d0: got %s need %s", fmt(obs0), fmt(e0));
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e0, e1;
        obs_t rst_val;
        bit found = 0;
        rst_val = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < S_FR + 8 && !found; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs1 !== e1 || obs0 !== e0) begin
                fails++;
                $display("FAIL seek: got %s need %s", fmt(obs1), fmt(e1));
            end
            if (x1 == 10'd20 && y1 == 10'd8) found = 1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL seek_timeout: got no x=20 y=8 need it");
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs1 !== rst_val || obs1 !== e1) begin
                fails++;
                $display("FAIL midrst_d1: got %s need %s",
                         fmt(obs1), fmt(rst_val));
            end
            checks++;
            if (obs0 !== rst_val || obs0 !== e0) begin
                fails++;
                $display("FAIL midrst_d0: got %s need %s",
                         fmt(obs0), fmt(rst_val));
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
                fails++;
                $display("FAIL restart: got %s need %s", fmt(obs1), fmt(e1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_pixel_enable();
        test_horizontal();
        test_vertical();
        test_frame_tick();
        test_bounds();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
